// File: rtl/audio_codec_i2s_emulator.sv
// -----------------------------------------------------------------------------
// audio_codec_i2s_emulator
//
// Codec-side (I2S master) stand-in for a WM8731. It generates BCLK and the
// shared ADC/DAC word-select and serializes parallel ADC sample pairs onto
// ADCDAT. It also deserializes DACDAT from the host into parallel DAC pairs.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   reset        asynchronous, active-high reset
//   adc_left     left ADC sample to transmit
//   adc_right    right ADC sample to transmit
//   adc_valid    ADC pair offered
//   adc_ready    holding register empty; pair taken on adc_valid & adc_ready
//   adc_underrun 1-cycle pulse: frame started without a new pair
//   dac_left     last received left DAC sample
//   dac_right    last received right DAC sample
//   dac_valid    1-cycle pulse: new pair on dac_left/dac_right
//   bclk         bit clock (2*CLK_DIV clk cycles per period)
//   adclrck      ADC word select, 0 = left slot, 1 = right slot
//   daclrck      DAC word select, identical to adclrck
//   adcdat       serial ADC data, changes on bclk falling edges
//   dacdat       serial DAC data from host, sampled on bclk rising edges
// -----------------------------------------------------------------------------
module audio_codec_i2s_emulator #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_BITS  = 32,
  parameter int unsigned CLK_DIV    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] adc_left,
  input  logic [DATA_WIDTH-1:0] adc_right,
  input  logic                  adc_valid,
  output logic                  adc_ready,
  output logic                  adc_underrun,
  output logic [DATA_WIDTH-1:0] dac_left,
  output logic [DATA_WIDTH-1:0] dac_right,
  output logic                  dac_valid,
  output logic                  bclk,
  output logic                  adclrck,
  output logic                  daclrck,
  output logic                  adcdat,
  input  logic                  dacdat
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DW_B     = BIT_W'(DATA_WIDTH);

  // Bit clock generation
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;

  // Frame position and ADC transmit path
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_lrck;
  logic                  r_adcdat;
  logic [DATA_WIDTH-1:0] r_tx_l, r_tx_r;
  logic [DATA_WIDTH-1:0] r_last_l, r_last_r;
  logic [DATA_WIDTH-1:0] r_hold_l, r_hold_r;
  logic                  r_hold_full;
  logic                  r_underrun;

  // DAC receive path
  logic [DATA_WIDTH-1:0] r_rx_l, r_rx_r;
  logic [DATA_WIDTH-1:0] r_dac_l, r_dac_r;
  logic                  r_dac_valid;

  logic                  w_tick;
  logic                  w_bclk_fall;
  logic                  w_bclk_rise;
  logic [BIT_W-1:0]      w_bit_next;
  logic                  w_next_right;
  logic [BIT_W-1:0]      w_k_next;
  logic [BIT_W-1:0]      w_k_cur;
  logic                  w_next_data;
  logic                  w_cur_data;
  logic                  w_frame_start;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rx_r_next;

  always_comb begin
    w_tick        = (r_div_cnt == DIV_LAST);
    w_bclk_fall   = w_tick & r_bclk;
    w_bclk_rise   = w_tick & ~r_bclk;
    w_bit_next    = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    w_next_right  = (w_bit_next >= SLOT_B);
    // Slot-relative bit position: after the coming falling edge, and now.
    w_k_next      = w_next_right ? (w_bit_next - SLOT_B) : w_bit_next;
    w_k_cur       = r_lrck ? (r_bit_cnt - SLOT_B) : r_bit_cnt;
    w_next_data   = (w_k_next != '0) && (w_k_next <= DW_B);
    w_cur_data    = (w_k_cur != '0) && (w_k_cur <= DW_B);
    w_frame_start = w_bclk_fall && (r_bit_cnt == BIT_LAST);
    w_accept      = adc_valid & ~r_hold_full;
    w_rx_r_next   = {r_rx_r[DATA_WIDTH-2:0], dacdat};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_lrck      <= 1'b0;
      r_adcdat    <= 1'b0;
      r_tx_l      <= '0;
      r_tx_r      <= '0;
      r_last_l    <= '0;
      r_last_r    <= '0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_hold_full <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_bclk_fall) begin
        r_bit_cnt <= w_bit_next;
        r_lrck    <= w_next_right;
        // I2S one-BCLK delay: slot bit 0 is a dead bit, data starts at k=1.
        if (w_next_data) begin
          if (w_next_right) begin
            r_adcdat <= r_tx_r[DATA_WIDTH-1];
            r_tx_r   <= {r_tx_r[DATA_WIDTH-2:0], 1'b0};
          end else begin
            r_adcdat <= r_tx_l[DATA_WIDTH-1];
            r_tx_l   <= {r_tx_l[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          r_adcdat <= 1'b0;
        end
      end
      // Frame start sees r_hold_full from before this cycle's accept, so a
      // pair accepted in the frame-start cycle waits for the next frame.
      if (w_frame_start) begin
        if (r_hold_full) begin
          r_tx_l      <= r_hold_l;
          r_tx_r      <= r_hold_r;
          r_last_l    <= r_hold_l;
          r_last_r    <= r_hold_r;
          r_hold_full <= 1'b0;
        end else begin
          r_tx_l     <= r_last_l;
          r_tx_r     <= r_last_r;
          r_underrun <= 1'b1;
        end
      end
      if (w_accept) begin
        r_hold_l    <= adc_left;
        r_hold_r    <= adc_right;
        r_hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_l      <= '0;
      r_rx_r      <= '0;
      r_dac_l     <= '0;
      r_dac_r     <= '0;
      r_dac_valid <= 1'b0;
    end else begin
      r_dac_valid <= 1'b0;
      if (w_bclk_rise && w_cur_data) begin
        if (r_lrck) begin
          r_rx_r <= w_rx_r_next;
          // Last right bit arrives this edge: publish both words together.
          if (w_k_cur == DW_B) begin
            r_dac_l     <= r_rx_l;
            r_dac_r     <= w_rx_r_next;
            r_dac_valid <= 1'b1;
          end
        end else begin
          r_rx_l <= {r_rx_l[DATA_WIDTH-2:0], dacdat};
        end
      end
    end
  end

  assign adc_ready    = ~r_hold_full;
  assign adc_underrun = r_underrun;
  assign dac_left     = r_dac_l;
  assign dac_right    = r_dac_r;
  assign dac_valid    = r_dac_valid;
  assign bclk         = r_bclk;
  assign adclrck      = r_lrck;
  assign daclrck      = r_lrck;
  assign adcdat       = r_adcdat;

endmodule

// File: doc/audio_codec_i2s_emulator.md
Name: audio_codec_i2s_emulator

Overview:
- Codec-side end of the audio serial interface; the Media Computer audio core is the host end.
- Generates BCLK, ADCLRCK and DACLRCK as the I2S master.
- Serializes parallel ADC sample pairs onto ADCDAT and deserializes DACDAT into parallel DAC sample pairs.
- Used as a synthesizable stand-in for the WM8731 in loopback and self-test builds, and as a bench peer.

Parameters:
- DATA_WIDTH, 24, bits per audio sample per channel; must be <= SLOT_BITS-1.
- SLOT_BITS, 32, BCLK periods per channel slot; frame = 2*SLOT_BITS BCLK periods.
- CLK_DIV, 8, clk cycles per BCLK half-period; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- adc_left  in  DATA_WIDTH  left sample to transmit on ADCDAT.
- adc_right  in  DATA_WIDTH  right sample to transmit on ADCDAT.
- adc_valid  in  1  ADC pair offered.
- adc_ready  out  1  holding register empty; pair accepted when adc_valid & adc_ready.
- adc_underrun  out  1  1-cycle pulse: frame started with no new pair.
- dac_left  out  DATA_WIDTH  last received left sample.
- dac_right  out  DATA_WIDTH  last received right sample.
- dac_valid  out  1  1-cycle pulse: new DAC pair on dac_left/dac_right.
- bclk  out  1  bit clock.
- adclrck  out  1  ADC word select: 0 = left slot, 1 = right slot.
- daclrck  out  1  DAC word select; identical to adclrck.
- adcdat  out  1  serial ADC data.
- dacdat  in  1  serial DAC data from host.

Behaviour:
- Reset values (asynchronous): bclk=0, adclrck=daclrck=0, adcdat=0, dac_left=dac_right=0, dac_valid=0, adc_underrun=0.
- Reset state: div_cnt=0, bit_cnt=0, holding empty (adc_ready=1), last-sent pair=0, shift register=0.
- BCLK generation:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - bclk toggles in the cycle after div_cnt=CLK_DIV-1.
  - First bclk rise occurs at cycle CLK_DIV after reset release; BCLK period = 2*CLK_DIV clk cycles.
- bit_cnt (0..2*SLOT_BITS-1) advances on each bclk falling edge and wraps.
  - k = bit_cnt mod SLOT_BITS.
  - adclrck = daclrck = (bit_cnt >= SLOT_BITS), updated on the falling edge.
- ADCDAT (I2S, one-BCLK delay), driven on falling edges:
  - k=0: 0.
  - k=1..DATA_WIDTH: sample bit DATA_WIDTH-k (MSB first).
  - k>DATA_WIDTH: 0.
- Frame start is the falling edge where bit_cnt wraps to 0.
  - Holding full: load shift register from holding, mark holding empty, update last-sent pair.
  - Holding empty: reload last-sent pair and pulse adc_underrun for 1 cycle.
  - Load sees holding state as registered at the start of the cycle. A pair accepted in the frame-start cycle therefore does not feed that frame: adc_underrun still pulses and the pair is kept for the next frame.
  - The initial frame after reset transmits zeros with no underrun pulse.
- ADC handshake:
  - One-entry holding register; adc_ready = holding empty.
  - adc_valid held while adc_ready=0 has no effect.
  - Inputs are sampled only on accept.
- DACDAT sampling:
  - Sampled on bclk rising edges at k=1..DATA_WIDTH, MSB first, into the left or right shift register according to the current slot.
  - Bits at k=0 and k>DATA_WIDTH are ignored.
  - On the rising edge of right slot k=DATA_WIDTH, both received words transfer to dac_left/dac_right and dac_valid pulses for 1 cycle.
  - This gives one dac_valid per frame; dac outputs hold between pulses.
- Reset mid-frame: immediate return to reset values; a partially received DAC pair is discarded with no dac_valid; a held ADC pair is lost.
- Frame period = 4*SLOT_BITS*CLK_DIV clk cycles (default 1024).

Test Plan:
- Reset release, no traffic -> bclk first rises at cycle 8 with period 16 cycles; adclrck toggles every 512 cycles; adcdat=0; adc_ready=1; no adc_underrun on the initial frame.
- Push adc_left=0xABCDEF, adc_right=0x123456 mid-frame -> adc_ready drops until next frame start. In the following frame the left slot gives delay bit 0, then 101010111100110111101111 MSB first, then 7 zeros; the right slot gives 0x123456 likewise.
- Loopback dacdat=adcdat, streaming distinct pairs each frame -> exactly one dac_valid per frame; dac_left/dac_right equal the pair sent that frame.
- No ADC pair offered for one frame after sending 0x000001/0xFFFFFF -> adc_underrun pulses once at frame start; the same pair is retransmitted.
- Offer two pairs back-to-back -> first accepted; second waits with adc_ready=0 until frame start, then is accepted next cycle and transmitted in the following frame. Separately, accept a pair in the frame-start cycle with holding empty -> adc_underrun pulses and the pair is sent the next frame.
- Assert reset during right slot bit 10 -> all outputs return to reset values within the cycle; no dac_valid; after release the timing restarts exactly as in scenario 1.
